// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared constants for the FTDI transmit feeder
package ftdi_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;

  localparam logic [1:0] FEED_IDLE      = 2'd0;
  localparam logic [1:0] FEED_WAIT_BUSY = 2'd1;
  localparam logic [1:0] FEED_WAIT_DONE = 2'd2;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two byte FIFO with occupancy count and flags
module sync_fifo
  import ftdi_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full      = count[ADDR_WIDTH];
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // RAM write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers wrap naturally; count tracks occupancy independently
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ftdi_tx_feeder.sv
// rtl/ftdi_tx_feeder.sv - FIFO front end for the FTDI UART transmitter (option FTDI_TX_FEEDER_CRLF_EN)
module ftdi_tx_feeder
  import ftdi_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_initialize,
  input  logic                  tx_ready,
  input  logic                  ftdi_dtr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] head;
  logic       accept;
  logic       fifo_pop;

  sync_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // no bypass: a full FIFO refuses input even while it is being drained
  assign in_ready = !full;

  // the transmitter latches tx_data on the same edge that tx_initialize is high
  assign accept        = (state == FEED_IDLE) && !empty && tx_ready && ftdi_dtr;
  assign tx_initialize = accept;

`ifdef FTDI_TX_FEEDER_CRLF_EN
  logic cr_sent;
  logic insert_cr;

  // an LF at the head is first sent as CR without being popped
  assign insert_cr = (head == CHAR_LF) && !cr_sent;
  assign tx_data   = insert_cr ? CHAR_CR : head;
  assign fifo_pop  = accept && !insert_cr;

  // remember that the CR for the current head LF has gone out
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cr_sent <= 1'b0;
    end else if (accept) begin
      cr_sent <= insert_cr;
    end
  end
`else
  assign tx_data  = head;
  assign fifo_pop = accept;
`endif

  // wait for the transmitter to go busy and then back to idle after each accept
  always_comb begin
    state_nxt = FEED_IDLE;
    case (state)
      FEED_IDLE:      state_nxt = accept ? FEED_WAIT_BUSY : FEED_IDLE;
      FEED_WAIT_BUSY: state_nxt = tx_ready ? FEED_WAIT_BUSY : FEED_WAIT_DONE;
      FEED_WAIT_DONE: state_nxt = tx_ready ? FEED_IDLE : FEED_WAIT_DONE;
      default:        state_nxt = FEED_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FEED_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_ftdi_tx_feeder.sv
// tb/tb_ftdi_tx_feeder.sv - self-checking bench for ftdi_tx_feeder
module tb_ftdi_tx_feeder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_initialize;
  logic       tx_ready;
  logic       ftdi_dtr;
  logic [4:0] count;
  logic       empty;
  logic       full;

  ftdi_tx_feeder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tx_data       (tx_data),
    .tx_initialize (tx_initialize),
    .tx_ready      (tx_ready),
    .ftdi_dtr      (ftdi_dtr),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus intent
  logic       rst;
  logic       dtr;
  logic       want_valid;
  logic [7:0] want_data;
  bit         rand_busy;
  bit         rand_xr;
  int         busy_len;

  // reference model: stored bytes and LF expansion progress
  logic [7:0] m_q[$];
  bit         cr_done;

  // transmitter model: 0 idle, 1 one-cycle lag after accept, 2 busy
  int         tx_phase;
  int         busy_left;
  int         ready_high_cnt;
  bit         xr_low;

  // observed pulses
  int         pulses;
  logic [7:0] obs_log[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic       exp_init;
    logic [7:0] exp_byte;
    bit         model_ready;
    @(negedge clk);
    case (tx_phase)
      0:       tx_ready = !xr_low;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'b0;
    endcase
    in_valid = want_valid;
    in_data  = want_data;
    ftdi_dtr = dtr;
    reset_n  = !rst;
    #1;
    if (rst) begin
      m_q.delete();
      cr_done        = 0;
      tx_phase       = 0;
      ready_high_cnt = 1;
      xr_low         = 0;
    end else begin
      model_ready = (m_q.size() < 16);
      check_eq("in_ready", in_ready, model_ready);
      check_eq("count", count, m_q.size());
      check_eq("empty", empty, m_q.size() == 0);
      check_eq("full", full, m_q.size() == 16);
      exp_init = (m_q.size() != 0) && tx_ready && dtr && (tx_phase == 0) && (ready_high_cnt != 0);
      check_eq("tx_init", tx_initialize, exp_init);
      if (tx_initialize) begin
        pulses++;
        obs_log.push_back(tx_data);
      end
      if (exp_init) begin
`ifdef FTDI_TX_FEEDER_CRLF_EN
        if (m_q[0] == 8'h0A && !cr_done) begin
          exp_byte = 8'h0D;
          cr_done  = 1;
        end else begin
          exp_byte = m_q.pop_front();
          cr_done  = 0;
        end
`else
        exp_byte = m_q.pop_front();
`endif
        check_eq("tx_data", tx_data, exp_byte);
      end
      if (want_valid && model_ready) m_q.push_back(want_data);
      // advance the transmitter across the coming edge
      if (exp_init) begin
        tx_phase       = 1;
        ready_high_cnt = 0;
        if (rand_busy) busy_len = $urandom_range(6, 1);
      end else begin
        case (tx_phase)
          1: begin
            tx_phase  = 2;
            busy_left = busy_len;
          end
          2: begin
            busy_left--;
            if (busy_left == 0) tx_phase = 0;
          end
          default: if (tx_ready) ready_high_cnt = 1;
        endcase
      end
      xr_low = (tx_phase == 0) && rand_xr && ($urandom_range(9) == 0);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    want_valid = 1'b1;
    want_data  = b;
    cycle();
    want_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    want_valid = 1'b0;
    dtr        = 1'b1;
    while ((m_q.size() != 0 || tx_phase != 0 || ready_high_cnt == 0) && guard < 3000) begin
      cycle();
      guard++;
    end
    cycle();
    check_eq("drain_empty", empty, 1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; tx_ready = 1'b1; ftdi_dtr = 1'b0;
    rst = 1; dtr = 0; want_valid = 0; want_data = 8'h00;
    rand_busy = 0; rand_xr = 0; busy_len = 20;
    cr_done = 0; tx_phase = 0; busy_left = 0; ready_high_cnt = 1; xr_low = 0; pulses = 0;

    cycle(); cycle();
    rst = 0;
    cycle();

    // reset with three bytes stored
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    cycle();
    check_eq("pre_rst_count", count, 3);
    rst = 1; cycle(); cycle();
    rst = 0; dtr = 1;
    cycle();
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_tx_init", tx_initialize, 0);

    // three bytes in order, each one pulse
    pulses = 0; obs_log.delete();
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    drain();
    check_eq("abc_pulses", pulses, 3);
    check_eq("abc_n", obs_log.size(), 3);
    for (int i = 0; i < 3; i++) check_eq("abc_byte", obs_log[i], 8'h41 + i);

    // fill to full with DTR low, refuse a 17th byte, then drain across the wrap
    dtr = 0;
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    want_valid = 1; want_data = 8'hEE;
    cycle();
    want_valid = 0;
    check_eq("full_flag", full, 1);
    check_eq("full_count", count, 16);
    check_eq("full_in_ready", in_ready, 0);
    pulses = 0; obs_log.delete();
    drain();
    check_eq("wrap_pulses", pulses, 16);
    for (int i = 0; i < 16; i++) check_eq("wrap_byte", obs_log[i], 8'hA0 + i);

    // push and accept in the same cycle at count 5
    dtr = 0;
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    pulses = 0; obs_log.delete();
    dtr = 1; want_valid = 1; want_data = 8'h77;
    cycle();
    check_eq("same_init", tx_initialize, 1);
    check_eq("same_in_ready", in_ready, 1);
    want_valid = 0; dtr = 0;
    cycle();
    check_eq("same_count", count, 5);
    drain();
    check_eq("same_pulses", pulses, 6);
    for (int i = 0; i < 5; i++) check_eq("same_byte", obs_log[i], 8'h11 + i);
    check_eq("same_last", obs_log[5], 8'h77);

    // DTR drops while the transmitter is busy
    pulses = 0; obs_log.delete();
    dtr = 1;
    push_byte(8'h61); push_byte(8'h62);
    for (int g = 0; g < 50 && tx_phase != 2; g++) cycle();
    dtr = 0;
    repeat (40) cycle();
    check_eq("dtr_hold_pulses", pulses, 1);
    check_eq("dtr_hold_count", count, 1);
    drain();
    check_eq("dtr_pulses", pulses, 2);
    check_eq("dtr_second", obs_log[1], 8'h62);

    // LF handling
    pulses = 0; obs_log.delete();
    push_byte(8'h48); push_byte(8'h0A);
    drain();
`ifdef FTDI_TX_FEEDER_CRLF_EN
    check_eq("lf_pulses", pulses, 3);
    check_eq("lf_b0", obs_log[0], 8'h48);
    check_eq("lf_b1", obs_log[1], 8'h0D);
    check_eq("lf_b2", obs_log[2], 8'h0A);
`else
    check_eq("lf_pulses", pulses, 2);
    check_eq("lf_b0", obs_log[0], 8'h48);
    check_eq("lf_b1", obs_log[1], 8'h0A);
`endif

    // randomized traffic with a reset mid-run
    rand_busy = 1; rand_xr = 1;
    for (int i = 0; i < 1500; i++) begin
      dtr        = ($urandom_range(7) != 0);
      want_valid = $urandom_range(1);
      want_data  = ($urandom_range(3) == 0) ? 8'h0A : 8'($urandom);
      rst        = (i == 700);
      cycle();
    end
    rst = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
